// File: rtl/ws_systolic_array.sv
// rtl/ws_systolic_array.sv - weight-stationary systolic matrix engine with skew/deskew and full-array stall
module ws_systolic_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       reuse_weights,
  input  logic                       cfg_signed,
  output logic                       busy,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_WIDTH*COLS-1:0] w_data,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] a_data,
  input  logic                       a_last,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [ACC_WIDTH*COLS-1:0]  r_data,
  output logic                       r_last
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;
  localparam int CW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PIPE = ROWS + COLS - 1;

  logic [1:0]            state;
  logic [CW-1:0]         w_cnt;
  logic                  mode_signed;
  logic                  stall, adv, a_fire, w_fire, r_fire;
  logic [PIPE-1:0]       v_pipe, l_pipe;
  logic [DATA_WIDTH-1:0] w_mem  [ROWS][COLS];
  logic [DATA_WIDTH-1:0] a_in   [ROWS];
  logic [DATA_WIDTH-1:0] row_in [ROWS];
  logic [DATA_WIDTH-1:0] act_q  [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  psum_q [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  col_out [COLS];

  assign r_valid = v_pipe[PIPE-1];
  assign r_last  = l_pipe[PIPE-1];
  assign stall   = r_valid && !r_ready;
  assign adv     = !stall;
  assign busy    = (state != S_IDLE);
  assign w_ready = (state == S_LOAD_W);
  assign a_ready = (state == S_STREAM) && !stall;
  assign w_fire  = w_valid && w_ready;
  assign a_fire  = a_valid && a_ready;
  assign r_fire  = r_valid && r_ready;

  // Job sequencing: mode latched at start, weight row counter, end on the r_last handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      w_cnt       <= '0;
      mode_signed <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_signed <= cfg_signed;
          w_cnt       <= '0;
          state       <= reuse_weights ? S_STREAM : S_LOAD_W;
        end
        S_LOAD_W: if (w_valid) begin
          if (w_cnt == CW'(ROWS-1)) begin
            w_cnt <= '0;
            state <= S_STREAM;
          end else begin
            w_cnt <= w_cnt + 1'b1;
          end
        end
        S_STREAM: if (a_fire && a_last) state <= S_DRAIN;
        default:  if (r_fire && r_last) state <= S_IDLE;
      endcase
    end
  end

  // Stationary weights: one row per accepted weight beat, kept across reuse jobs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          w_mem[i][j] <= '0;
    end else if (w_fire) begin
      for (int j = 0; j < COLS; j++)
        w_mem[w_cnt][j] <= w_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Bubbles enter as zeros so idle cycles never disturb in-flight sums
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      a_in[i] = a_fire ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Valid/last tags travel alongside the data for the full array latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else if (adv) begin
      v_pipe[0] <= a_fire;
      l_pipe[0] <= a_fire && a_last;
      for (int k = 1; k < PIPE; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        l_pipe[k] <= l_pipe[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign row_in[gi] = a_in[gi];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sk [gi];
      // Row gi enters the array gi advances after row 0
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) sk[k] <= '0;
        end else if (adv) begin
          sk[0] <= a_in[gi];
          for (int k = 1; k < gi; k++) sk[k] <= sk[k-1];
        end
      end
      assign row_in[gi] = sk[gi-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic [DATA_WIDTH-1:0] a_src, act_r;
      logic [ACC_WIDTH-1:0]  p_src, a_ext, w_ext, psum_r;
      if (gj == 0) begin : g_a_edge
        assign a_src = row_in[gi];
      end else begin : g_a_link
        assign a_src = act_q[gi][gj-1];
      end
      if (gi == 0) begin : g_p_edge
        assign p_src = '0;
      end else begin : g_p_link
        assign p_src = psum_q[gi-1][gj];
      end
      // Extending both operands to ACC_WIDTH makes the truncated product equal the extended product
      assign a_ext = {{(ACC_WIDTH-DATA_WIDTH){mode_signed & a_src[DATA_WIDTH-1]}}, a_src};
      assign w_ext = {{(ACC_WIDTH-DATA_WIDTH){mode_signed & w_mem[gi][gj][DATA_WIDTH-1]}}, w_mem[gi][gj]};
      // MAC cell: pass activation right, add own product to the sum from above
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          act_r  <= '0;
          psum_r <= '0;
        end else if (adv) begin
          act_r  <= a_src;
          psum_r <= p_src + a_ext * w_ext;
        end
      end
      assign act_q[gi][gj]  = act_r;
      assign psum_q[gi][gj] = psum_r;
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_deskew
    if (gj == COLS-1) begin : g_direct
      assign col_out[gj] = psum_q[ROWS-1][gj];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] dk [COLS-1-gj];
      // Early columns wait so a whole result vector presents in one cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < COLS-1-gj; k++) dk[k] <= '0;
        end else if (adv) begin
          dk[0] <= psum_q[ROWS-1][gj];
          for (int k = 1; k < COLS-1-gj; k++) dk[k] <= dk[k-1];
        end
      end
      assign col_out[gj] = dk[COLS-2-gj];
    end
    assign r_data[gj*ACC_WIDTH +: ACC_WIDTH] = col_out[gj];
  end

endmodule

// File: doc/ws_systolic_array.md
# ws_systolic_array

Parametrised weight-stationary systolic matrix engine: a ROWS×COLS grid of multiply-accumulate cells holding a preloaded weight matrix W. Activation vectors are streamed in, and one result vector per input vector is streamed out, with r[j] = Σ_i a[i]·W[i][j]. It generalises the fixed-size array core with runtime signed/unsigned mode, weight reuse across jobs, input skew/output deskew, and valid/ready flow control with full-array stall. It sits between the multi-mode buffers (activation/weight sources) and the accumulator/result buffer.

## Interface
- DATA_WIDTH, 8: width of one activation or weight element.
- ROWS, 4: array rows; equals the activation vector length.
- COLS, 4: array columns; equals the result vector length.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(ROWS): width of each result element.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a job; honoured only in IDLE.
- reuse_weights  in  1  sampled with start; 1 skips LOAD_W and keeps the stored W.
- cfg_signed  in  1  sampled with start; 1 selects two's-complement operands, 0 selects unsigned.
- busy  out  1  high in every state except IDLE.
- w_valid / w_ready  in / out  1 / 1  weight-row handshake.
- w_data  in  DATA_WIDTH*COLS  one row of W; element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- a_valid / a_ready  in / out  1 / 1  activation handshake.
- a_data  in  DATA_WIDTH*ROWS  activation vector; element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- a_last  in  1  marks the final vector of the job.
- r_valid / r_ready  out / in  1 / 1  result handshake.
- r_data  out  ACC_WIDTH*COLS  result vector; element j at bits [j*ACC_WIDTH +: ACC_WIDTH].
- r_last  out  1  marks the result belonging to the a_last vector.

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE → LOAD_W on start with reuse_weights=0.
- IDLE → STREAM on start with reuse_weights=1.
- LOAD_W:
  - w_ready=1.
  - Each w handshake writes row k (k=0 first) into PE row k.
  - After ROWS handshakes → STREAM.
- STREAM:
  - a_ready = !stall.
  - Handshake with a_last=1 → DRAIN.
- DRAIN:
  - Accepts no input.
  - → IDLE on the r handshake with r_last=1.
- stall = r_valid && !r_ready.
  - While stall is high, every datapath, skew, deskew and valid/last pipeline register holds.
  - Otherwise, all of them advance every cycle.
- Cycles with no a handshake inject zeros with valid=0 (bubbles). Bubbles never produce r_valid.
- Skew: activation row i enters after i delay stages.
- Dataflow: activations move right one PE per advance; partial sums move down one PE per advance.
- Deskew: column j output is delayed COLS-1-j stages, so all elements of a result vector present together.
- Arithmetic:
  - Each product is sign-extended (cfg_signed=1) or zero-extended (cfg_signed=0) to ACC_WIDTH.
  - Sums wrap modulo 2^ACC_WIDTH.
  - The mode is latched at start and held for the whole job.
- Results leave in input order, with exactly one result per accepted vector.
- Boundary conditions:
  - start while busy: ignored.
  - w_valid outside LOAD_W: ignored.
  - a_valid outside STREAM: ignored.
  - a_last on the first vector: legal; gives a single result with r_last=1.
  - reuse_weights=1 after reset: uses W=0, so all results are 0.
- Reset (at any time, including mid-job):
  - FSM → IDLE.
  - Weights, pipelines and latched mode cleared.
  - In-flight results discarded.

## Timing
- Reset values: busy=0, w_ready=0, a_ready=0, r_valid=0, r_last=0, r_data=0.
- start accepted in cycle t:
  - busy=1 from t+1.
  - w_ready=1 from t+1 (reload), or a_ready=1 from t+1 (reuse).
- Last weight handshake in cycle t → a_ready=1 in t+1.
- Activation accepted in cycle t with no stall → r_valid=1 in cycle t+ROWS+COLS-1, i.e. latency 7 for 4×4.
- Throughput: one vector per cycle while r_ready=1.
- Stall response: a_ready falls combinationally in the same cycle r_valid && !r_ready; the r outputs hold stable until the handshake.
- r_last handshake in cycle t → IDLE and busy=0 in t+1.
- start is accepted again in that next cycle.

## Test plan
- Identity W (4×4, unsigned), a=[1,2,3,4] with a_last=1 → r=[1,2,3,4], r_last=1, r_valid exactly 7 cycles after the a handshake; busy=0 one cycle after the r handshake.
- W all 0xFF, a all 127:
  - cfg_signed=1 → every r element = -508.
  - cfg_signed=0 → every r element = 129540.
- 8 back-to-back vectors with r_ready low for 5 cycles mid-stream → all 8 results correct and in order, no duplicates; a_ready=0 and r_data stable during the stall.
- Job 1 loads W=2·I. Job 2 with reuse_weights=1 → w_ready never rises, a_ready rises one cycle after start, and a=[5,6,7,8] → r=[10,12,14,16].
- Assert rst mid-STREAM with 3 results in flight → all outputs 0 immediately and FSM in IDLE. A following reuse_weights=1 job → r=[0,0,0,0].
- start during DRAIN, plus w_valid pulses in STREAM → both ignored; results unaffected.
